// File: rtl/kypd_pkg.sv
// Shared constants for the keypad entry display:
// glyph table, blank pattern and default digit count.
package kypd_pkg;

    localparam int NUM_DIGITS_DEF = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        return GLYPH[v];
    endfunction

endpackage

// File: rtl/kypd_if.sv
// Keypad strobes in, multiplexed display and status out.
// master = stimulus side, slave = display block.
interface kypd_if
    import kypd_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
) ();

    logic [3:0]            key;
    logic                  key_valid;
    logic                  del;
    logic                  clear;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
    logic [3:0]            count;
    logic                  overflow;

    modport master (
        output key, key_valid, del, clear,
        input  an, seg, dp, count, overflow
    );

    modport slave (
        input  key, key_valid, del, clear,
        output an, seg, dp, count, overflow
    );

endinterface

// File: rtl/kypd_scan_timer.sv
// Digit scan timer: prescaler of REFRESH_DIV clocks per slot
// and a scan index that walks 0..NUM_DIGITS-1.
module kypd_scan_timer
    import kypd_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] scan_idx,
    output logic       scan_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [PW-1:0] presc;

    assign scan_tick = (presc == PRE_LAST);

    // Prescaler wraps at the slot end; index advances on that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (scan_tick) begin
            presc    <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            presc    <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/kypd_entry_display.sv
// Keypad entry buffer with count/overflow tracking and a
// registered, multiplexed seven-segment display driver.
module kypd_entry_display
    import kypd_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int REFRESH_DIV = 100000
) (
    input  logic   clk,
    input  logic   rst,
    kypd_if.slave  bus
);

    localparam logic [3:0] FULL     = 4'(NUM_DIGITS);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [3:0]            digits [NUM_DIGITS];
    logic [3:0]            count_q;
    logic                  ovf_q;
    logic [2:0]            scan_idx;
    logic                  tick_unused;
    logic [3:0]            cur_digit;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;

    kypd_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .scan_idx  (scan_idx),
        .scan_tick (tick_unused)
    );

    // Buffer and status update; clear beats del beats key_valid
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (bus.del) begin
            if (count_q != 4'd0) begin
                for (int i = 0; i < NUM_DIGITS - 1; i++)
                    digits[i] <= digits[i+1];
                digits[NUM_DIGITS-1] <= '0;
                count_q <= count_q - 4'd1;
            end
        end else if (bus.key_valid) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--)
                digits[i] <= digits[i-1];
            digits[0] <= bus.key;
            if (count_q == FULL) ovf_q <= 1'b1;
            else                 count_q <= count_q + 4'd1;
        end
    end

    // Decode the digit under the scan index; unoccupied slots blank
    always_comb begin
        cur_digit = '0;
        an_d      = '1;
        lit       = ({1'b0, scan_idx} < count_q);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) == scan_idx) begin
                cur_digit = digits[i];
                if (lit) an_d[i] = 1'b0;
            end
        end
        seg_d = lit ? hex_glyph(cur_digit) : SEG_BLANK;
        dp_d  = !(ovf_q && lit && scan_idx == IDX_LAST);
    end

    // Register display outputs for glitch-free pins
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an       = an_q;
    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

endmodule
